pc_unit: RTL and testbench
==========================

# pc_unit

Per-thread program-counter and branch unit that consumes the compare result produced by the thread's ALU. It latches the ALU's NZP flags into a 3-bit condition register during UPDATE. During EXECUTE it computes the thread's next PC: sequential increment, conditional branch, or call/return through a small hardware return stack. One instance sits beside each thread's ALU and LSU inside a core; the scheduler takes `next_pc` from thread 0.

## Interface
Parameters:
- `DATA_BITS`, 8, width of `alu_out` and immediates.
- `PROGRAM_MEM_ADDR_BITS`, 8, PC width.
- `STACK_DEPTH`, 4, return-stack entries; legal range 1..7.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: thread active; when low, all state holds.
- `core_state` in 3: core phase; EXECUTE = 3'b101, UPDATE = 3'b110.
- `decoded_nzp` in 3: branch condition mask {P,Z,N}.
- `decoded_immediate` in DATA_BITS: branch or call target, low PROGRAM_MEM_ADDR_BITS bits used.
- `decoded_nzp_write_enable` in 1: the instruction is CMP; latch flags in UPDATE.
- `decoded_pc_mux` in 1: the instruction is BRnzp.
- `decoded_call` in 1: the instruction is CAL.
- `decoded_ret` in 1: the instruction is RET.
- `alu_out` in DATA_BITS: ALU result; for CMP, bit2 = gt (P), bit1 = eq (Z), bit0 = lt (N).
- `current_pc` in PROGRAM_MEM_ADDR_BITS: PC of the instruction in flight.
- `next_pc` out PROGRAM_MEM_ADDR_BITS: registered next PC.
- `nzp` out 3: current condition register {P,Z,N}.
- `stack_depth` out 3: number of valid return-stack entries.
- `stack_error` out 1: sticky flag for call overflow or return underflow.

## Operation
- Reset: `next_pc`, `nzp`, `stack_depth` and `stack_error` all 0; stack contents are don't-care.
- With `enable` low, no register changes regardless of `core_state`.
- UPDATE with `decoded_nzp_write_enable`=1: `nzp` <= `alu_out[2:0]`. Otherwise `nzp` holds.
- EXECUTE computes `next_pc` with fixed priority RET > CAL > BRnzp > increment:
  - RET, depth>0: `next_pc` <= top of stack; depth decrements.
  - RET, depth=0: `next_pc` <= `current_pc`+1; `stack_error` <= 1.
  - CAL, depth<STACK_DEPTH: push `current_pc`+1; `next_pc` <= immediate; depth increments.
  - CAL, depth=STACK_DEPTH: no push; `next_pc` <= `current_pc`+1; `stack_error` <= 1.
  - BRnzp: if (`nzp` & `decoded_nzp`) != 0, `next_pc` <= immediate, else `current_pc`+1.
  - None of the above: `next_pc` <= `current_pc`+1.
- Arithmetic is modulo 2^PROGRAM_MEM_ADDR_BITS, so `current_pc`=255 gives 0 at the default width. The immediate is truncated to PROGRAM_MEM_ADDR_BITS.
- In states other than EXECUTE and UPDATE, all state holds.
- `stack_error` clears only on reset.

## Timing
- `next_pc` is valid from the clock edge that ends the EXECUTE cycle, which is 1 cycle of latency. It remains stable through UPDATE, when the scheduler samples it.
- `nzp` updates on the edge ending UPDATE. A branch in the next instruction's EXECUTE sees the new flags. A BRnzp in the same instruction as CMP is not possible.
- A branch evaluated in EXECUTE uses the `nzp` value registered before that edge.
- The stack push/pop and the `stack_depth` change occur on the same edge as the `next_pc` update.
- Reset asserted in any state, including mid-EXECUTE, wins over all updates on that edge.

## Configuration
- `PC_CALL_STACK_EN` defined: return stack, CAL, RET and `stack_error` behave as above.
- Not defined:
  - No stack storage is built.
  - `decoded_call` and `decoded_ret` are ignored; those instructions fall through the priority to BRnzp or increment.
  - `stack_depth` and `stack_error` are tied to 0.
  - Ports remain present.

## Test plan
- Reset, then EXECUTE with `current_pc`=8'h05 and no control bits -> `next_pc`=8'h06; `nzp`=0; `stack_error`=0.
- UPDATE with CMP and `alu_out`=8'h04, then EXECUTE BRnzp with mask 3'b100, imm 8'h20, pc 8'h10 -> `next_pc`=8'h20. Repeat with mask 3'b011 -> 8'h11.
- EXECUTE at `current_pc`=8'hFF with no control bits -> `next_pc`=8'h00 (wrap).
- With `PC_CALL_STACK_EN`: CAL at pc 8'h03 with imm 8'h40 -> `next_pc`=8'h40 and depth 1. Then RET at pc 8'h45 -> `next_pc`=8'h04 and depth 0.
- With `PC_CALL_STACK_EN`: 5 CALs with STACK_DEPTH=4 -> 5th gives `next_pc`=pc+1, depth stays 4, `stack_error`=1. RET at depth 0 -> pc+1 with `stack_error` held at 1.
- `enable`=0 through EXECUTE/UPDATE with CMP and CAL asserted -> `next_pc`, `nzp` and depth unchanged. Reset mid-sequence -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - per-thread program counter, NZP condition register and optional return stack
// Optional feature: define PC_CALL_STACK_EN to build the CAL/RET return stack and stack_error.
// Without it, CAL/RET fall through to branch/increment and stack_depth/stack_error read 0.
module pc_unit #(
  parameter int DATA_BITS             = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic [2:0]                       decoded_nzp,
  input  logic [DATA_BITS-1:0]             decoded_immediate,
  input  logic                             decoded_nzp_write_enable,
  input  logic                             decoded_pc_mux,
  input  logic                             decoded_call,
  input  logic                             decoded_ret,
  input  logic [DATA_BITS-1:0]             alu_out,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic [2:0]                       nzp,
  output logic [2:0]                       stack_depth,
  output logic                             stack_error
);

  localparam int         AW         = PROGRAM_MEM_ADDR_BITS;
  localparam logic [2:0] ST_EXECUTE = 3'b101;
  localparam logic [2:0] ST_UPDATE  = 3'b110;

  logic [AW-1:0] next_pc_q, next_pc_d;
  logic [2:0]    nzp_q, nzp_d;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] target;
  logic [AW-1:0] branch_pc;
  logic          exec_en;
  logic          upd_en;
  logic          branch_taken;
  logic          unused_alu_hi;

  // Upper ALU bits carry no flag information.
  assign unused_alu_hi = ^alu_out[DATA_BITS-1:3];

  assign exec_en      = enable && (core_state == ST_EXECUTE);
  assign upd_en       = enable && (core_state == ST_UPDATE);
  assign pc_inc       = current_pc + 1'b1;
  assign target       = decoded_immediate[AW-1:0];
  assign branch_taken = decoded_pc_mux && ((nzp_q & decoded_nzp) != 3'b000);
  assign branch_pc    = branch_taken ? target : pc_inc;

  // Condition register: CMP latches the ALU flags at the end of UPDATE.
  always_comb begin
    nzp_d = nzp_q;
    if (upd_en && decoded_nzp_write_enable) begin
      nzp_d = alu_out[2:0];
    end
  end

`ifdef PC_CALL_STACK_EN
  logic [2:0]    depth_q, depth_d;
  logic          error_q, error_d;
  logic [AW-1:0] stack_q [STACK_DEPTH];
  logic [AW-1:0] stack_d [STACK_DEPTH];
  logic [AW-1:0] stack_top;
  logic          push;

  // Top of stack is the entry just below the current depth.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (3'(i + 1) == depth_q) begin
        stack_top = stack_q[i];
      end
    end
  end

  // Next PC with priority RET > CAL > BRnzp > increment; bad CAL/RET set the sticky error.
  always_comb begin
    next_pc_d = next_pc_q;
    depth_d   = depth_q;
    error_d   = error_q;
    push      = 1'b0;
    if (exec_en) begin
      if (decoded_ret) begin
        if (depth_q != 3'd0) begin
          next_pc_d = stack_top;
          depth_d   = depth_q - 3'd1;
        end else begin
          next_pc_d = pc_inc;
          error_d   = 1'b1;
        end
      end else if (decoded_call) begin
        if (depth_q < 3'(STACK_DEPTH)) begin
          push      = 1'b1;
          next_pc_d = target;
          depth_d   = depth_q + 3'd1;
        end else begin
          next_pc_d = pc_inc;
          error_d   = 1'b1;
        end
      end else begin
        next_pc_d = branch_pc;
      end
    end
  end

  // Push writes the return address into the slot at the current depth.
  always_comb begin
    stack_d = stack_q;
    if (push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (3'(i) == depth_q) begin
          stack_d[i] = pc_inc;
        end
      end
    end
  end

  // Stack contents need no reset; depth alone says which entries are valid.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  // Depth and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= 3'd0;
      error_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      error_q <= error_d;
    end
  end

  assign stack_depth = depth_q;
  assign stack_error = error_q;
`else
  logic unused_stack_ctl;

  // CAL and RET are ignored in this build and fall through to branch/increment.
  assign unused_stack_ctl = decoded_call ^ decoded_ret;

  // Next PC is either the branch target or the sequential increment.
  always_comb begin
    next_pc_d = next_pc_q;
    if (exec_en) begin
      next_pc_d = branch_pc;
    end
  end

  assign stack_depth = 3'd0;
  assign stack_error = 1'b0;
`endif

  // PC and flag registers; reset overrides any update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc_q <= '0;
      nzp_q     <= 3'b000;
    end else begin
      next_pc_q <= next_pc_d;
      nzp_q     <= nzp_d;
    end
  end

  assign next_pc = next_pc_q;
  assign nzp     = nzp_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - randomized self-checking bench for pc_unit against a queue-based model
module tb_pc_unit;

  localparam logic [2:0] EXE   = 3'b101;
  localparam logic [2:0] UPD   = 3'b110;
  localparam int         DEPTH = 4;
`ifdef PC_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic [2:0] decoded_nzp;
  logic [7:0] decoded_immediate;
  logic       decoded_nzp_write_enable;
  logic       decoded_pc_mux;
  logic       decoded_call;
  logic       decoded_ret;
  logic [7:0] alu_out;
  logic [7:0] current_pc;
  wire  [7:0] next_pc;
  wire  [2:0] nzp;
  wire  [2:0] stack_depth;
  wire        stack_error;

  pc_unit dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_nzp              (decoded_nzp),
    .decoded_immediate        (decoded_immediate),
    .decoded_nzp_write_enable (decoded_nzp_write_enable),
    .decoded_pc_mux           (decoded_pc_mux),
    .decoded_call             (decoded_call),
    .decoded_ret              (decoded_ret),
    .alu_out                  (alu_out),
    .current_pc               (current_pc),
    .next_pc                  (next_pc),
    .nzp                      (nzp),
    .stack_depth              (stack_depth),
    .stack_error              (stack_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference state: a queue of return addresses stands in for the stack.
  int m_pc  = 0;
  int m_nzp = 0;
  int m_err = 0;
  int m_stack[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_step();
    int pcn;
    pcn = (int'(current_pc) + 1) % 256;
    if (reset) begin
      m_pc = 0;
      m_nzp = 0;
      m_err = 0;
      m_stack.delete();
    end else if (enable && core_state == UPD) begin
      if (decoded_nzp_write_enable) m_nzp = int'(alu_out) % 8;
    end else if (enable && core_state == EXE) begin
      if (STACK_EN && decoded_ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_pc = pcn;
          m_err = 1;
        end
      end else if (STACK_EN && decoded_call) begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back(pcn);
          m_pc = int'(decoded_immediate);
        end else begin
          m_pc = pcn;
          m_err = 1;
        end
      end else if (decoded_pc_mux && ((m_nzp & int'(decoded_nzp)) != 0)) begin
        m_pc = int'(decoded_immediate);
      end else begin
        m_pc = pcn;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input logic [2:0] st, input bit we,
                       input bit mux, input bit cal, input bit ret, input logic [2:0] mask,
                       input logic [7:0] imm, input logic [7:0] alu, input logic [7:0] pc);
    reset = rst;
    enable = en;
    core_state = st;
    decoded_nzp_write_enable = we;
    decoded_pc_mux = mux;
    decoded_call = cal;
    decoded_ret = ret;
    decoded_nzp = mask;
    decoded_immediate = imm;
    alu_out = alu;
    current_pc = pc;
    model_step();
    @(posedge clk);
    #1;
    check("next_pc", int'(next_pc), m_pc);
    check("nzp", int'(nzp), m_nzp);
    check("stack_depth", int'(stack_depth), m_stack.size());
    check("stack_error", int'(stack_error), m_err);
  endtask

  initial begin
    logic [2:0] st;
    int         r;

    cycle(1, 1, 3'b000, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00, 8'h00);
    check("reset_pc", int'(next_pc), 0);
    check("reset_nzp", int'(nzp), 0);
    check("reset_err", int'(stack_error), 0);

    cycle(0, 1, EXE, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00, 8'h05);
    check("seq_inc", int'(next_pc), 8'h06);

    cycle(0, 1, UPD, 1, 0, 0, 0, 3'b000, 8'h00, 8'h04, 8'h05);
    check("cmp_latch", int'(nzp), 3'b100);
    cycle(0, 1, EXE, 0, 1, 0, 0, 3'b100, 8'h20, 8'h00, 8'h10);
    check("br_taken", int'(next_pc), 8'h20);
    cycle(0, 1, EXE, 0, 1, 0, 0, 3'b011, 8'h20, 8'h00, 8'h10);
    check("br_not_taken", int'(next_pc), 8'h11);

    cycle(0, 1, EXE, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00, 8'hFF);
    check("pc_wrap", int'(next_pc), 8'h00);

    cycle(0, 1, EXE, 0, 0, 1, 0, 3'b000, 8'h40, 8'h00, 8'h03);
`ifdef PC_CALL_STACK_EN
    check("cal_target", int'(next_pc), 8'h40);
    check("cal_depth", int'(stack_depth), 1);
`endif
    cycle(0, 1, EXE, 0, 0, 0, 1, 3'b000, 8'h00, 8'h00, 8'h45);
`ifdef PC_CALL_STACK_EN
    check("ret_target", int'(next_pc), 8'h04);
    check("ret_depth", int'(stack_depth), 0);
`endif

    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, EXE, 0, 0, 1, 0, 3'b000, 8'h80, 8'h00, 8'(8'h10 + i));
    end
`ifdef PC_CALL_STACK_EN
    check("ovf_pc", int'(next_pc), 8'h15);
    check("ovf_depth", int'(stack_depth), 4);
    check("ovf_err", int'(stack_error), 1);
`endif
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, EXE, 0, 0, 0, 1, 3'b000, 8'h00, 8'h00, 8'h30);
    end
`ifdef PC_CALL_STACK_EN
    check("unf_pc", int'(next_pc), 8'h31);
    check("unf_err_held", int'(stack_error), 1);
`endif

    cycle(0, 1, EXE, 0, 0, 1, 0, 3'b000, 8'h60, 8'h00, 8'h50);
    cycle(0, 0, EXE, 0, 0, 1, 0, 3'b000, 8'h70, 8'h00, 8'h90);
    cycle(0, 0, UPD, 1, 0, 0, 0, 3'b000, 8'h00, 8'h01, 8'h90);
    check("hold_nzp", int'(nzp), 3'b100);
`ifdef PC_CALL_STACK_EN
    check("hold_pc", int'(next_pc), 8'h60);
    check("hold_depth", int'(stack_depth), 1);
`else
    check("hold_pc", int'(next_pc), 8'h51);
`endif

    cycle(1, 1, EXE, 0, 0, 1, 0, 3'b000, 8'h77, 8'h00, 8'h22);
    check("midreset_pc", int'(next_pc), 0);
    check("midreset_nzp", int'(nzp), 0);
    check("midreset_depth", int'(stack_depth), 0);
    check("midreset_err", int'(stack_error), 0);

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      st = (r < 5) ? EXE : (r < 8) ? UPD : 3'($urandom);
      cycle(($urandom % 60) == 0, ($urandom % 8) != 0, st,
            ($urandom % 2) == 0, ($urandom % 2) == 0,
            ($urandom % 4) == 0, ($urandom % 4) == 0,
            3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
